// File: rtl/con3_pkg.sv
// Shared constants, FSM encoding and sizing helper for the con3 servo decoder.
package con3_pkg;

  localparam int TICKS_PER_CYCLE = 256;
  localparam int TO_W = 16;

  typedef enum logic [1:0] {
    ST_SYNC      = 2'd0,
    ST_WAIT_RISE = 2'd1,
    ST_MEASURE   = 2'd2
  } state_e;

  function automatic int w_width(input int hc);
    int w;
    w = $clog2((hc + 1) * TICKS_PER_CYCLE + 1);
    return (w < 10) ? 10 : w;
  endfunction

endpackage

// File: rtl/con3_edge_sync.sv
// Input synchronizer with registered level/rise/fall and a fill-ready flag.
// CON3_DEC_GLITCH_FILTER_EN adds a 3-sample stability filter when FILT=1.
module con3_edge_sync
  import con3_pkg::*;
#(
  parameter int STAGES = 2,
  parameter bit FILT   = 1'b0
) (
  input  logic clk,
  input  logic module_rst,
  input  logic d_i,
  output logic lvl_o,
  output logic rise_o,
  output logic fall_o,
  output logic rdy_o
);

  logic [STAGES-1:0] sync_q;
  logic              raw;
  logic              cur;
  logic              lvl_q;
  logic              rise_q;
  logic              fall_q;

  assign raw = sync_q[STAGES-1];

`ifdef CON3_DEC_GLITCH_FILTER_EN
  localparam int FD = FILT ? 3 : 0;
  logic [1:0] hist_q;
  logic       filt_q;

  // raw plus two history samples = three stable clk cycles
  always_ff @(posedge clk or posedge module_rst) begin
    if (module_rst) begin
      hist_q <= '0;
      filt_q <= 1'b0;
    end else begin
      hist_q <= {hist_q[0], raw};
      if (raw == hist_q[0] && raw == hist_q[1])
        filt_q <= raw;
    end
  end

  assign cur = FILT ? filt_q : raw;
`else
  localparam int FD = 0;
  assign cur = raw;
`endif

  localparam int VL = STAGES + FD + 1;
  logic [VL-1:0] v_q;

  always_ff @(posedge clk or posedge module_rst) begin
    if (module_rst) begin
      sync_q <= '0;
      lvl_q  <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      v_q    <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      lvl_q  <= cur;
      rise_q <= cur & ~lvl_q;
      fall_q <= ~cur & lvl_q;
      v_q    <= {v_q[VL-2:0], 1'b1};
    end
  end

  assign lvl_o  = lvl_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;
  assign rdy_o  = v_q[VL-1];

endmodule

// File: rtl/con3_decoder.sv
// con3 servo PWM decoder: measures high time in 256 kHz ticks, reports angle.
// Optional glitch filter on servo_in: define CON3_DEC_GLITCH_FILTER_EN.
module con3_decoder
  import con3_pkg::*;
#(
  parameter int HIGH_CYCLE     = 1,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 8
) (
  input  logic       clk,
  input  logic       module_rst,
  input  logic       clk_256kHz,
  input  logic       servo_in,
  output logic [7:0] angle,
  output logic       angle_valid,
  output logic       angle_error,
  output logic       signal_lost
);

  localparam int WW = w_width(HIGH_CYCLE);
  localparam logic [WW-1:0] W_LO =
    WW'(HIGH_CYCLE * TICKS_PER_CYCLE);
  localparam logic [WW-1:0] W_OVF =
    WW'((HIGH_CYCLE + 1) * TICKS_PER_CYCLE);
  localparam logic [TO_W-1:0] TO_LIM =
    TO_W'(TIMEOUT_CYCLES * TICKS_PER_CYCLE);

  logic srv_lvl;
  logic srv_rise;
  logic srv_fall;
  logic srv_rdy;
  logic tick;
  logic tck_lvl_unused;
  logic tck_fall_unused;
  logic tck_rdy_unused;

  con3_edge_sync #(
    .STAGES (SYNC_STAGES),
    .FILT   (1'b1)
  ) u_srv (
    .clk        (clk),
    .module_rst (module_rst),
    .d_i        (servo_in),
    .lvl_o      (srv_lvl),
    .rise_o     (srv_rise),
    .fall_o     (srv_fall),
    .rdy_o      (srv_rdy)
  );

  con3_edge_sync #(
    .STAGES (SYNC_STAGES),
    .FILT   (1'b0)
  ) u_tick (
    .clk        (clk),
    .module_rst (module_rst),
    .d_i        (clk_256kHz),
    .lvl_o      (tck_lvl_unused),
    .rise_o     (tick),
    .fall_o     (tck_fall_unused),
    .rdy_o      (tck_rdy_unused)
  );

  state_e          state_q, state_d;
  logic [WW-1:0]   w_q, w_d, w_inc;
  logic [7:0]      angle_q, angle_d;
  logic            valid_q, valid_d;
  logic            err_q, err_d;
  logic [TO_W-1:0] to_q, to_d, to_inc;
  logic            lost_q, lost_d;

  always_ff @(posedge clk or posedge module_rst) begin
    if (module_rst) begin
      state_q <= ST_SYNC;
      w_q     <= '0;
      angle_q <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      to_q    <= '0;
      lost_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      angle_q <= angle_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      to_q    <= to_d;
      lost_q  <= lost_d;
    end
  end

  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    angle_d = angle_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    // a tick in the same cycle as an edge is counted first
    w_inc   = tick ? w_q + 1'b1 : w_q;

    unique case (state_q)
      ST_SYNC: begin
        w_d = '0;
        if (srv_rdy && !srv_lvl)
          state_d = ST_WAIT_RISE;
      end
      ST_WAIT_RISE: begin
        w_d = '0;
        if (srv_rise)
          state_d = ST_MEASURE;
      end
      ST_MEASURE: begin
        w_d = w_inc;
        if (w_inc >= W_OVF) begin
          err_d   = 1'b1;
          state_d = ST_SYNC;
        end else if (srv_fall) begin
          state_d = ST_WAIT_RISE;
          if (w_inc >= W_LO) begin
            valid_d = 1'b1;
            // W_LO is a multiple of 256, so the offset is the low byte
            angle_d = w_inc[7:0];
          end else begin
            err_d = 1'b1;
          end
        end
      end
      default: state_d = ST_SYNC;
    endcase

    to_inc = (tick && to_q != TO_LIM) ? to_q + 1'b1 : to_q;
    to_d   = srv_rise ? '0 : to_inc;
    lost_d = lost_q;
    if (valid_d)
      lost_d = 1'b0;
    else if (to_d == TO_LIM)
      lost_d = 1'b1;
  end

  assign angle       = angle_q;
  assign angle_valid = valid_q;
  assign angle_error = err_q;
  assign signal_lost = lost_q;

endmodule
